// File: rtl/d_ff_pipe.sv
// d_ff_pipe
//   Parameterised chain of DEPTH rising-edge D register stages, each WIDTH
//   bits wide, on a single clock. With WIDTH=1, DEPTH=1 it is a plain D
//   flip-flop. Adds synchronous reset, clock enable, inverted output,
//   per-stage taps and a registered change-detect flag on the last stage.
//
// Parameters
//   WIDTH   : bit width of d and of every stage
//   DEPTH   : number of stages (>=1); d->q latency in enabled edges
//   RST_VAL : value loaded into every stage on reset
//
// Ports
//   clk     in   1            rising-edge clock
//   rst     in   1            synchronous active-high reset (overrides en, d)
//   en      in   1            1 = shift, 0 = hold
//   d       in   WIDTH        data into stage 0
//   q       out  WIDTH        stage DEPTH-1 contents
//   q_n     out  WIDTH        bitwise inverse of q
//   taps    out  WIDTH*DEPTH  stage i at [i*WIDTH +: WIDTH]
//   changed out  1            1 for one cycle after q took a new, different value
module d_ff_pipe #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [WIDTH-1:0]       d,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       q_n,
    output logic [WIDTH*DEPTH-1:0] taps,
    output logic                   changed
);

    logic [WIDTH-1:0] r_stage    [DEPTH];
    logic [WIDTH-1:0] w_stage_in [DEPTH];
    logic             r_changed;

    // Each stage's next value when enabled: d for stage 0, the previous
    // stage otherwise. Kept as a wire array so no stage ever indexes -1.
    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign w_stage_in[g] = d;
        end else begin : g_rest
            assign w_stage_in[g] = r_stage[g-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_stage[g] <= RST_VAL;
            end else if (en) begin
                r_stage[g] <= w_stage_in[g];
            end
        end

        assign taps[g*WIDTH +: WIDTH] = r_stage[g];
    end

    // Compare the value about to enter the last stage with what it holds
    // now, so the flag rises on the same edge q changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_changed <= 1'b0;
        end else if (en) begin
            r_changed <= (w_stage_in[DEPTH-1] != r_stage[DEPTH-1]);
        end else begin
            r_changed <= 1'b0;
        end
    end

    assign q       = r_stage[DEPTH-1];
    assign q_n     = ~r_stage[DEPTH-1];
    assign changed = r_changed;

endmodule

// File: tb/tb_d_ff_pipe.sv
module tb_d_ff_pipe;

    // Instance A: plain DFF (WIDTH=1, DEPTH=1, RST_VAL=0)
    // Instance B: WIDTH=8, DEPTH=4, RST_VAL=0xA5
    logic        clk = 1'b0;
    logic        rst_a, en_a;
    logic [0:0]  d_a;
    logic [0:0]  q_a, q_n_a, taps_a;
    logic        changed_a;

    logic        rst_b, en_b;
    logic [7:0]  d_b, q_b, q_n_b;
    logic [31:0] taps_b;
    logic        changed_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;   // rising edges at 10, 30, 50, ...

    d_ff_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .d(d_a),
        .q(q_a), .q_n(q_n_a), .taps(taps_a), .changed(changed_a)
    );

    d_ff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) u_b (
        .clk(clk), .rst(rst_b), .en(en_b), .d(d_b),
        .q(q_b), .q_n(q_n_b), .taps(taps_b), .changed(changed_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each model keeps the history of values sampled on enabled edges since
    // the last reset (only the newest DEPTH matter). Stage i holds the value
    // sampled i enabled edges ago, or RST_VAL if fewer edges have happened.
    function automatic logic [7:0] stage_of(input logic [7:0] h[$], input int i,
                                            input logic [7:0] rv);
        if (h.size() > i) return h[h.size()-1-i];
        return rv;
    endfunction

    logic [7:0] hist_a[$];
    logic [7:0] hist_b[$];
    bit         ok_a = 0, ok_b = 0;
    logic       chg_a = 0, chg_b = 0;

    always @(posedge clk) begin
        logic [7:0] old;
        if (rst_a) begin
            hist_a.delete(); ok_a = 1; chg_a = 0;
        end else if (en_a) begin
            old = stage_of(hist_a, 0, 8'h00);
            hist_a.push_back({7'b0, d_a});
            if (hist_a.size() > 1) void'(hist_a.pop_front());
            chg_a = (stage_of(hist_a, 0, 8'h00) != old);
        end else begin
            chg_a = 0;
        end

        if (rst_b) begin
            hist_b.delete(); ok_b = 1; chg_b = 0;
        end else if (en_b) begin
            old = stage_of(hist_b, 3, 8'hA5);
            hist_b.push_back(d_b);
            if (hist_b.size() > 4) void'(hist_b.pop_front());
            chg_b = (stage_of(hist_b, 3, 8'hA5) != old);
        end else begin
            chg_b = 0;
        end
    end

    // Compare process: every falling edge, once the model has seen a reset.
    always @(negedge clk) begin
        logic [7:0]  eq;
        logic [31:0] et;
        if (ok_a) begin
            eq = stage_of(hist_a, 0, 8'h00);
            check("A.q",       {31'b0, q_a},       {31'b0, eq[0]});
            check("A.q_n",     {31'b0, q_n_a},     {31'b0, ~eq[0]});
            check("A.taps",    {31'b0, taps_a},    {31'b0, eq[0]});
            check("A.changed", {31'b0, changed_a}, {31'b0, chg_a});
        end
        if (ok_b) begin
            eq = stage_of(hist_b, 3, 8'hA5);
            for (int i = 0; i < 4; i++) et[i*8 +: 8] = stage_of(hist_b, i, 8'hA5);
            check("B.q",       {24'b0, q_b},       {24'b0, eq});
            check("B.q_n",     {24'b0, q_n_b},     {24'b0, ~eq});
            check("B.taps",    taps_b,             et);
            check("B.changed", {31'b0, changed_b}, {31'b0, chg_b});
        end
    end

    // Wait for n rising edges, then move 5 time units past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #5;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_a = 1; en_a = 1; d_a = 0;
        rst_b = 1; en_b = 0; d_b = 8'h00;

        // Reset on the first edge (t=10), now t=15
        edges(1);
        rst_a = 0; rst_b = 0;
        check("A.q after reset",   {31'b0, q_a},   32'h0);
        check("A.q_n after reset", {31'b0, q_n_a}, 32'h1);
        check("B.taps after reset", taps_b, 32'hA5A5A5A5);

        // ---- Basic DFF: d->1 at t=80, next edge t=90
        #65;
        d_a = 1;                         // t=80
        check("A.q before edge", {31'b0, q_a}, 32'h0);
        edges(1);                        // t=95
        check("A.q after d=1",       {31'b0, q_a},       32'h1);
        check("A.q_n after d=1",     {31'b0, q_n_a},     32'h0);
        check("A.changed pulse",     {31'b0, changed_a}, 32'h1);
        edges(1);                        // t=115
        check("A.changed cleared",   {31'b0, changed_a}, 32'h0);
        edges(6);                        // t=235
        check("A.q steady",          {31'b0, q_a},       32'h1);

        // ---- Sampling: glitch d between edges
        #3; d_a = 0; #6; d_a = 1;        // back before edge at 250
        edges(1);
        check("A.q glitch ignored",       {31'b0, q_a},       32'h1);
        check("A.changed glitch ignored", {31'b0, changed_a}, 32'h0);

        // ---- Enable: bring q to 0, then hold with en=0 while d=1
        d_a = 0;
        edges(1);
        check("A.q back to 0", {31'b0, q_a}, 32'h0);
        en_a = 0; d_a = 1;
        edges(3);
        check("A.q held en=0",       {31'b0, q_a},       32'h0);
        check("A.changed held en=0", {31'b0, changed_a}, 32'h0);
        en_a = 1;
        edges(1);
        check("A.q after en=1",       {31'b0, q_a},       32'h1);
        check("A.changed after en=1", {31'b0, changed_a}, 32'h1);

        // ---- Pipeline: 11,22,33,44 on consecutive edges
        en_b = 1; d_b = 8'h11;
        edges(1); d_b = 8'h22;
        check("B.taps 1 edge", taps_b, 32'hA5A5A511);
        edges(1); d_b = 8'h33;
        edges(1); d_b = 8'h44;
        edges(1); d_b = 8'h55;
        check("B.q after 4 edges",    {24'b0, q_b}, 32'h11);
        check("B.taps after 4 edges", taps_b,       32'h11223344);
        check("B.changed on arrival", {31'b0, changed_b}, 32'h1);
        edges(1);
        check("B.q 0x22", {24'b0, q_b}, 32'h22);
        edges(1);
        check("B.q 0x33", {24'b0, q_b}, 32'h33);
        edges(1);
        check("B.q 0x44", {24'b0, q_b}, 32'h44);
        check("B.q_n 0x44", {24'b0, q_n_b}, 32'hBB);

        // ---- Reset mid-stream with en=1 on the same edge
        rst_b = 1; d_b = 8'h99;
        edges(1);
        rst_b = 0; d_b = 8'h77;
        check("B.taps reset",    taps_b,              32'hA5A5A5A5);
        check("B.q reset",       {24'b0, q_b},        32'hA5);
        check("B.changed reset", {31'b0, changed_b},  32'h0);
        edges(3);
        check("B.q refill 3 edges", {24'b0, q_b}, 32'hA5);
        check("B.taps refill 3",    taps_b,       32'hA5777777);
        edges(1);
        check("B.q refill 4 edges", {24'b0, q_b}, 32'h77);
        check("B.changed refill",   {31'b0, changed_b}, 32'h1);
        edges(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
